// File: rtl/dispatch_unit.sv
// Dispatch stage: decodes the fetch-queue head, renames destinations through
// a tag counter and issues into the integer, multiply or load/store queues.
module dispatch_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] ifetch_pc_4,
    input  logic [31:0] ifetch_intruction,
    input  logic        ifetch_empty,
    output logic        Dispatch_ren,
    output logic        Dispatch_jmp,
    output logic [31:0] Dispatch_jmp_addr,
    output logic [31:0] dispatch_rs_data,
    output logic [31:0] dispatch_rt_data,
    output logic        dispatch_rs_data_valid,
    output logic        dispatch_rt_data_valid,
    output logic [4:0]  dispatch_rs_tag,
    output logic [4:0]  dispatch_rt_tag,
    output logic [4:0]  dispatch_rd_tag,
    output logic [3:0]  dispatch_opcode,
    output logic [4:0]  dispatch_shfamt,
    output logic [15:0] dispatch_imm_ld_st,
    output logic        dispatch_en_integer_A,
    output logic        dispatch_en_integer_B,
    output logic        dispatch_en_ld_st,
    output logic        dispatch_en_mul,
    input  logic        issueque_integer_full_A,
    input  logic        issueque_integer_full_B,
    input  logic        issueque_full_ld_st,
    input  logic        issueque_mul_full,
    output logic        flush,
    output logic        Retire_store_ready
);

    logic [31:0] r_rf [32];
    logic [31:0] r_vld;
    logic [4:0]  r_tag [32];
    logic [4:0]  r_cnt;

    logic [31:0] r_rs_data, r_rt_data;
    logic        r_rs_vld, r_rt_vld;
    logic [4:0]  r_rs_tag, r_rt_tag, r_rd_tag, r_shf;
    logic [3:0]  r_opc;
    logic [15:0] r_imm;
    logic        r_en_a, r_en_b, r_en_ls, r_en_mul, r_st;

    logic [5:0]  w_op, w_fn;
    logic [4:0]  w_rs, w_rt, w_rd, w_dst;
    logic [3:0]  w_opc;
    logic        w_int, w_mul, w_mem, w_jmp, w_addi, w_store;
    logic        w_dst_rd, w_dst_rt, w_imm_en;
    logic        w_full, w_fire;
    logic [31:0] w_rs_data, w_rt_data;
    logic        w_rs_vld, w_rt_vld;
    logic [4:0]  w_rs_tag, w_rt_tag;

    assign w_op = ifetch_intruction[31:26];
    assign w_fn = ifetch_intruction[5:0];
    assign w_rs = ifetch_intruction[25:21];
    assign w_rt = ifetch_intruction[20:16];
    assign w_rd = ifetch_intruction[15:11];

    always_comb begin
        w_opc    = 4'd0;
        w_int    = 1'b0;
        w_mul    = 1'b0;
        w_mem    = 1'b0;
        w_jmp    = 1'b0;
        w_addi   = 1'b0;
        w_store  = 1'b0;
        w_dst_rd = 1'b0;
        w_dst_rt = 1'b0;
        w_imm_en = 1'b0;
        case (w_op)
            6'h00: begin
                w_dst_rd = 1'b1;
                w_int    = 1'b1;
                case (w_fn)
                    6'h20: w_opc = 4'b0000;
                    6'h22: w_opc = 4'b0001;
                    6'h24: w_opc = 4'b0010;
                    6'h25: w_opc = 4'b0011;
                    6'h2A: w_opc = 4'b0100;
                    6'h00: w_opc = 4'b0101;
                    6'h02: w_opc = 4'b0110;
                    6'h18: begin
                        w_opc = 4'b1010;
                        w_int = 1'b0;
                        w_mul = 1'b1;
                    end
                    default: begin
                        w_dst_rd = 1'b0;
                        w_int    = 1'b0;
                    end
                endcase
            end
            6'h08: begin
                w_opc = 4'b0111; w_int = 1'b1;
                w_dst_rt = 1'b1; w_addi = 1'b1;
            end
            6'h04: begin
                w_opc = 4'b1000; w_int = 1'b1; w_imm_en = 1'b1;
            end
            6'h05: begin
                w_opc = 4'b1001; w_int = 1'b1; w_imm_en = 1'b1;
            end
            6'h23: begin
                w_opc = 4'b1100; w_mem = 1'b1;
                w_dst_rt = 1'b1; w_imm_en = 1'b1;
            end
            6'h2B: begin
                w_opc = 4'b1101; w_mem = 1'b1;
                w_store = 1'b1; w_imm_en = 1'b1;
            end
            6'h02: w_jmp = 1'b1;
            default: ;
        endcase
    end

    // Jumps and undecodable words never wait on a queue.
    assign w_full = (w_int & issueque_integer_full_A & issueque_integer_full_B)
                  | (w_mul & issueque_mul_full)
                  | (w_mem & issueque_full_ld_st);
    assign Dispatch_ren = reset & ~ifetch_empty & ~w_full;
    assign w_fire = Dispatch_ren & (w_int | w_mul | w_mem);
    assign Dispatch_jmp = Dispatch_ren & w_jmp;
    assign flush = Dispatch_jmp;
    assign Dispatch_jmp_addr = Dispatch_jmp ?
        {ifetch_pc_4[31:28], ifetch_intruction[25:0], 2'b00} : 32'd0;

    assign w_dst = w_dst_rd ? w_rd : (w_dst_rt ? w_rt : 5'd0);

    always_comb begin
        w_rs_vld  = (w_rs == 5'd0) | r_vld[w_rs];
        w_rs_data = (w_rs == 5'd0) ? 32'd0 : r_rf[w_rs];
        w_rs_tag  = w_rs_vld ? 5'd0 : r_tag[w_rs];
        w_rt_vld  = (w_rt == 5'd0) | r_vld[w_rt];
        w_rt_data = (w_rt == 5'd0) ? 32'd0 : r_rf[w_rt];
        w_rt_tag  = w_rt_vld ? 5'd0 : r_tag[w_rt];
        if (w_addi) begin
            w_rt_vld  = 1'b1;
            w_rt_data = {{16{ifetch_intruction[15]}}, ifetch_intruction[15:0]};
            w_rt_tag  = 5'd0;
        end
    end

    // No writeback path exists here, so the file only ever holds its reset image.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) r_rf[i] <= 32'(i);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt <= 5'd0;
            r_vld <= '1;
            for (int i = 0; i < 32; i++) r_tag[i] <= 5'd0;
        end else if (w_fire) begin
            r_cnt <= r_cnt + 5'd1;
            if (w_dst != 5'd0) begin
                r_vld[w_dst] <= 1'b0;
                r_tag[w_dst] <= r_cnt;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rs_data <= '0; r_rt_data <= '0;
            r_rs_vld  <= 1'b0; r_rt_vld <= 1'b0;
            r_rs_tag  <= '0; r_rt_tag <= '0; r_rd_tag <= '0;
            r_opc     <= '0; r_shf <= '0; r_imm <= '0;
            r_en_a    <= 1'b0; r_en_b <= 1'b0;
            r_en_ls   <= 1'b0; r_en_mul <= 1'b0; r_st <= 1'b0;
        end else begin
            r_rs_data <= w_fire ? w_rs_data : 32'd0;
            r_rt_data <= w_fire ? w_rt_data : 32'd0;
            r_rs_vld  <= w_fire & w_rs_vld;
            r_rt_vld  <= w_fire & w_rt_vld;
            r_rs_tag  <= w_fire ? w_rs_tag : 5'd0;
            r_rt_tag  <= w_fire ? w_rt_tag : 5'd0;
            r_rd_tag  <= w_fire ? r_cnt : 5'd0;
            r_opc     <= w_fire ? w_opc : 4'd0;
            r_shf     <= w_fire ? ifetch_intruction[10:6] : 5'd0;
            r_imm     <= (w_fire & w_imm_en) ? ifetch_intruction[15:0] : 16'd0;
            r_en_a    <= w_fire & w_int & ~issueque_integer_full_A;
            r_en_b    <= w_fire & w_int & issueque_integer_full_A;
            r_en_ls   <= w_fire & w_mem;
            r_en_mul  <= w_fire & w_mul;
            r_st      <= w_fire & w_store;
        end
    end

    assign dispatch_rs_data       = r_rs_data;
    assign dispatch_rt_data       = r_rt_data;
    assign dispatch_rs_data_valid = r_rs_vld;
    assign dispatch_rt_data_valid = r_rt_vld;
    assign dispatch_rs_tag        = r_rs_tag;
    assign dispatch_rt_tag        = r_rt_tag;
    assign dispatch_rd_tag        = r_rd_tag;
    assign dispatch_opcode        = r_opc;
    assign dispatch_shfamt        = r_shf;
    assign dispatch_imm_ld_st     = r_imm;
    assign dispatch_en_integer_A  = r_en_a;
    assign dispatch_en_integer_B  = r_en_b;
    assign dispatch_en_ld_st      = r_en_ls;
    assign dispatch_en_mul        = r_en_mul;
    assign Retire_store_ready     = r_st;

endmodule

// File: tb/tb_dispatch_unit.sv
// Directed bench for dispatch_unit: decode, rename, routing, stall,
// jump, store and asynchronous reset behaviour.
module tb_dispatch_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] ifetch_pc_4 = 32'd0;
    logic [31:0] ifetch_intruction = 32'd0;
    logic        ifetch_empty = 1'b1;
    logic        Dispatch_ren, Dispatch_jmp;
    logic [31:0] Dispatch_jmp_addr;
    logic [31:0] rs_data, rt_data;
    logic        rs_v, rt_v;
    logic [4:0]  rs_tag, rt_tag, rd_tag, shf;
    logic [3:0]  opc;
    logic [15:0] imm;
    logic        en_a, en_b, en_ls, en_mul;
    logic        full_a = 1'b0, full_b = 1'b0, full_ls = 1'b0, full_mul = 1'b0;
    logic        flush, st_rdy;

    int checks = 0;
    int errors = 0;

    dispatch_unit dut (
        .clock(clock), .reset(reset),
        .ifetch_pc_4(ifetch_pc_4),
        .ifetch_intruction(ifetch_intruction),
        .ifetch_empty(ifetch_empty),
        .Dispatch_ren(Dispatch_ren), .Dispatch_jmp(Dispatch_jmp),
        .Dispatch_jmp_addr(Dispatch_jmp_addr),
        .dispatch_rs_data(rs_data), .dispatch_rt_data(rt_data),
        .dispatch_rs_data_valid(rs_v), .dispatch_rt_data_valid(rt_v),
        .dispatch_rs_tag(rs_tag), .dispatch_rt_tag(rt_tag),
        .dispatch_rd_tag(rd_tag), .dispatch_opcode(opc),
        .dispatch_shfamt(shf), .dispatch_imm_ld_st(imm),
        .dispatch_en_integer_A(en_a), .dispatch_en_integer_B(en_b),
        .dispatch_en_ld_st(en_ls), .dispatch_en_mul(en_mul),
        .issueque_integer_full_A(full_a), .issueque_integer_full_B(full_b),
        .issueque_full_ld_st(full_ls), .issueque_mul_full(full_mul),
        .flush(flush), .Retire_store_ready(st_rdy)
    );

    always #5 clock = ~clock;

    // Present one instruction at the negedge, let it be taken at the posedge.
    task automatic present(input logic [31:0] ins, input logic [31:0] pc4);
        @(negedge clock);
        ifetch_intruction = ins;
        ifetch_pc_4 = pc4;
        ifetch_empty = 1'b0;
        #1;
    endtask

    task automatic take();
        @(posedge clock);
        #1;
        ifetch_empty = 1'b1;
    endtask

    task automatic test_reset();
        ifetch_intruction = 32'h0080F820;
        ifetch_empty = 1'b0;
        #2 reset = 1'b0;
        #1;
        checks++;
        if (Dispatch_ren !== 1'b0) begin
            errors++; $display("FAIL reset_ren got %b want 0", Dispatch_ren);
        end
        @(posedge clock); #1;
        checks++;
        if ({en_a, en_b, en_ls, en_mul, st_rdy, rs_v, rt_v} !== 7'd0) begin
            errors++; $display("FAIL reset_flags got %b want 0",
                {en_a, en_b, en_ls, en_mul, st_rdy, rs_v, rt_v});
        end
        checks++;
        if ({rs_data, rt_data, rs_tag, rt_tag, rd_tag, opc, shf, imm} !== '0) begin
            errors++; $display("FAIL reset_data got nonzero want 0");
        end
        checks++;
        if ({Dispatch_jmp, flush, Dispatch_jmp_addr} !== '0) begin
            errors++; $display("FAIL reset_jmp got %b %b %h want 0",
                Dispatch_jmp, flush, Dispatch_jmp_addr);
        end
        ifetch_empty = 1'b1;
        @(negedge clock);
        reset = 1'b1;
        #1;
        checks++;
        if (Dispatch_ren !== 1'b0) begin
            errors++; $display("FAIL empty_ren got %b want 0", Dispatch_ren);
        end
    endtask

    task automatic test_add();
        present(32'h0080F820, 32'h4);
        checks++;
        if (Dispatch_ren !== 1'b1) begin
            errors++; $display("FAIL add_ren got %b want 1", Dispatch_ren);
        end
        take();
        checks++;
        if ({en_a, en_b, en_mul, en_ls, opc} !== {4'b1000, 4'b0000}) begin
            errors++; $display("FAIL add_route got %b%b%b%b op %b want 1000 op 0000",
                en_a, en_b, en_mul, en_ls, opc);
        end
        checks++;
        if ({rs_data, rs_v, rt_data, rt_v, rd_tag} !== {32'd4, 1'b1, 32'd0, 1'b1, 5'd0}) begin
            errors++; $display("FAIL add_ops got rs %h/%b rt %h/%b tag %0d want 4/1 0/1 0",
                rs_data, rs_v, rt_data, rt_v, rd_tag);
        end
    endtask

    task automatic test_dependency();
        present(32'h00BF1018, 32'h8);
        take();
        checks++;
        if ({en_mul, en_a, en_b, opc} !== {3'b100, 4'b1010}) begin
            errors++; $display("FAIL mul_route got %b%b%b op %b want 100 op 1010",
                en_mul, en_a, en_b, opc);
        end
        checks++;
        if ({rs_data, rs_v, rt_v, rt_tag, rd_tag} !== {32'd5, 1'b1, 1'b0, 5'd0, 5'd1}) begin
            errors++; $display("FAIL mul_ops got rs %h/%b rtv %b rtt %0d rd %0d want 5/1 0 0 1",
                rs_data, rs_v, rt_v, rt_tag, rd_tag);
        end
    endtask

    task automatic test_same_edge();
        present(32'h00210820, 32'hC);
        take();
        checks++;
        if ({rs_data, rs_v, rt_data, rt_v, rd_tag} !== {32'd1, 1'b1, 32'd1, 1'b1, 5'd2}) begin
            errors++; $display("FAIL self_add got rs %h/%b rt %h/%b tag %0d want 1/1 1/1 2",
                rs_data, rs_v, rt_data, rt_v, rd_tag);
        end
        present(32'h00201820, 32'h10);
        take();
        checks++;
        if ({rs_v, rs_tag, rd_tag} !== {1'b0, 5'd2, 5'd3}) begin
            errors++; $display("FAIL renamed_src got v %b tag %0d rd %0d want 0 2 3",
                rs_v, rs_tag, rd_tag);
        end
    endtask

    task automatic test_routing();
        full_a = 1'b1;
        present(32'h0080F820, 32'h14);
        take();
        checks++;
        if ({en_a, en_b, rd_tag} !== {2'b01, 5'd4}) begin
            errors++; $display("FAIL route_b got A %b B %b tag %0d want 0 1 4",
                en_a, en_b, rd_tag);
        end
        full_b = 1'b1;
        present(32'h0080F820, 32'h18);
        checks++;
        if (Dispatch_ren !== 1'b0) begin
            errors++; $display("FAIL stall_ren got %b want 0", Dispatch_ren);
        end
        take();
        checks++;
        if ({en_a, en_b, en_ls, en_mul, rd_tag} !== '0) begin
            errors++; $display("FAIL stall_en got %b%b%b%b tag %0d want 0000 0",
                en_a, en_b, en_ls, en_mul, rd_tag);
        end
        full_a = 1'b0;
        full_b = 1'b0;
        present(32'h0080F820, 32'h18);
        take();
        checks++;
        if ({en_a, en_b, rd_tag} !== {2'b10, 5'd5}) begin
            errors++; $display("FAIL after_stall got A %b B %b tag %0d want 1 0 5",
                en_a, en_b, rd_tag);
        end
    endtask

    task automatic test_jump();
        present(32'h08000010, 32'h4);
        checks++;
        if ({Dispatch_ren, Dispatch_jmp, flush, Dispatch_jmp_addr} !== {3'b111, 32'h40}) begin
            errors++; $display("FAIL jump got ren %b jmp %b flush %b addr %h want 1 1 1 00000040",
                Dispatch_ren, Dispatch_jmp, flush, Dispatch_jmp_addr);
        end
        take();
        checks++;
        if ({en_a, en_b, en_ls, en_mul} !== 4'd0) begin
            errors++; $display("FAIL jump_en got %b%b%b%b want 0000",
                en_a, en_b, en_ls, en_mul);
        end
    endtask

    task automatic test_store();
        present(32'hAC220008, 32'h44);
        take();
        checks++;
        if ({en_ls, st_rdy, en_a, opc, imm} !== {3'b110, 4'b1101, 16'h0008}) begin
            errors++; $display("FAIL store got ls %b st %b A %b op %b imm %h want 1 1 0 1101 0008",
                en_ls, st_rdy, en_a, opc, imm);
        end
        checks++;
        if ({rs_v, rs_tag, rt_v, rt_tag, rd_tag} !== {1'b0, 5'd2, 1'b0, 5'd1, 5'd6}) begin
            errors++; $display("FAIL store_ops got %b %0d %b %0d %0d want 0 2 0 1 6",
                rs_v, rs_tag, rt_v, rt_tag, rd_tag);
        end
        @(posedge clock); #1;
        checks++;
        if ({st_rdy, en_ls} !== 2'b00) begin
            errors++; $display("FAIL store_pulse got st %b ls %b want 0 0", st_rdy, en_ls);
        end
    endtask

    task automatic test_branch_addi();
        present(32'h1422000C, 32'h48);
        take();
        checks++;
        if ({en_a, opc, imm, rd_tag} !== {1'b1, 4'b1001, 16'h000C, 5'd7}) begin
            errors++; $display("FAIL bne got A %b op %b imm %h tag %0d want 1 1001 000c 7",
                en_a, opc, imm, rd_tag);
        end
        present(32'h2005FFFF, 32'h4C);
        take();
        checks++;
        if ({en_a, opc, rt_data, rt_v, rs_data, rs_v, rd_tag}
            !== {1'b1, 4'b0111, 32'hFFFFFFFF, 1'b1, 32'd0, 1'b1, 5'd8}) begin
            errors++; $display("FAIL addi got op %b rt %h/%b rs %h/%b tag %0d want 0111 ffffffff/1 0/1 8",
                opc, rt_data, rt_v, rs_data, rs_v, rd_tag);
        end
    endtask

    task automatic test_undecodable();
        present(32'hFC000000, 32'h50);
        checks++;
        if ({Dispatch_ren, Dispatch_jmp} !== 2'b10) begin
            errors++; $display("FAIL undec_ren got %b jmp %b want 1 0", Dispatch_ren, Dispatch_jmp);
        end
        take();
        checks++;
        if ({en_a, en_b, en_ls, en_mul, opc} !== '0) begin
            errors++; $display("FAIL undec_en got %b%b%b%b op %b want 0",
                en_a, en_b, en_ls, en_mul, opc);
        end
        present(32'h00A53020, 32'h54);
        take();
        checks++;
        if ({rs_v, rs_tag, rt_tag, rd_tag} !== {1'b0, 5'd8, 5'd8, 5'd9}) begin
            errors++; $display("FAIL after_undec got v %b rs %0d rt %0d rd %0d want 0 8 8 9",
                rs_v, rs_tag, rt_tag, rd_tag);
        end
    endtask

    task automatic test_reset_mid();
        present(32'h00A53020, 32'h58);
        take();
        checks++;
        if ({en_a, rd_tag} !== {1'b1, 5'd10}) begin
            errors++; $display("FAIL pre_reset got A %b tag %0d want 1 10", en_a, rd_tag);
        end
        #1 reset = 1'b0;
        #1;
        checks++;
        if ({en_a, rd_tag, rs_tag, rs_v} !== '0) begin
            errors++; $display("FAIL mid_reset got A %b tag %0d rs %0d v %b want 0",
                en_a, rd_tag, rs_tag, rs_v);
        end
        @(negedge clock);
        reset = 1'b1;
        present(32'h03FF0820, 32'h5C);
        take();
        checks++;
        if ({rs_data, rs_v, rt_data, rt_v, rd_tag} !== {32'd31, 1'b1, 32'd31, 1'b1, 5'd0}) begin
            errors++; $display("FAIL post_reset got rs %h/%b rt %h/%b tag %0d want 1f/1 1f/1 0",
                rs_data, rs_v, rt_data, rt_v, rd_tag);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_dependency();
        test_same_edge();
        test_routing();
        test_jump();
        test_store();
        test_branch_addi();
        test_undecodable();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
